// File: rtl/accum_drain_scheduler.sv
// Drains finished accumulator rows to the unified buffer through a 2-entry skid FIFO,
// sharing the accumulator read port with the accumulate path, which always has priority.
module accum_drain_scheduler #(
   parameter int MUL_SIZE = 32,
   parameter int ACC_W    = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      done_i,
   input  logic [7:0]                V_dim_i,
   input  logic [7:0]                U_dim_i,
   input  logic                      mac_read_req_i,
   input  logic [9:0]                mac_addr_rd_i,
   output logic                      accum_rd_en_o,
   output logic [9:0]                accum_rd_addr_o,
   input  logic [MUL_SIZE*ACC_W-1:0] accum_rd_data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [MUL_SIZE*ACC_W-1:0] out_data_o,
   output logic [9:0]                out_addr_o,
   output logic                      out_last_o,
   output logic                      busy_o,
   output logic                      drain_done_o,
   output logic                      overflow_err_o
);

   localparam int DW = MUL_SIZE * ACC_W;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [14:0]   row_count_q;
   logic [14:0]   rd_ptr_q;
   logic          inflight_q;
   logic [9:0]    inflight_addr_q;
   logic          inflight_last_q;
   logic [DW-1:0] fifo_data_q [2];
   logic [9:0]    fifo_addr_q [2];
   logic          fifo_last_q [2];
   logic          wr_idx_q, rd_idx_q;
   logic [1:0]    count_q;
   logic          drain_done_q, overflow_q;

   logic [15:0]   dim_prod;
   logic [14:0]   n_rows;
   logic          pop, push, drain_issue, is_last, done_pulse_d;
   logic [1:0]    occ_after;

   assign dim_prod = V_dim_i * U_dim_i;
   assign n_rows   = 15'(dim_prod >> 5);
   assign pop      = (count_q != 2'd0) && out_ready_i;
   assign push     = inflight_q;
   assign is_last  = (rd_ptr_q == row_count_q - 15'd1);

   // Occupancy counts the pop happening this cycle so that back-to-back rows flow at full rate
   assign occ_after   = count_q - {1'b0, pop} + {1'b0, inflight_q};
   assign drain_issue = (state_q == DRAIN) && !mac_read_req_i && (occ_after < 2'd2);

   assign accum_rd_en_o   = mac_read_req_i || drain_issue;
   assign accum_rd_addr_o = mac_read_req_i ? mac_addr_rd_i : rd_ptr_q[9:0];

   assign out_valid_o    = (count_q != 2'd0);
   assign out_data_o     = fifo_data_q[rd_idx_q];
   assign out_addr_o     = fifo_addr_q[rd_idx_q];
   assign out_last_o     = fifo_last_q[rd_idx_q] && out_valid_o;
   assign busy_o         = (state_q != IDLE);
   assign drain_done_o   = drain_done_q;
   assign overflow_err_o = overflow_q;

   always_comb begin
      state_d      = state_q;
      done_pulse_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (done_i) begin
               if (n_rows != 15'd0) state_d = DRAIN;
               else                 done_pulse_d = 1'b1;
            end
         end
         DRAIN: begin
            if (drain_issue && is_last) state_d = FLUSH;
         end
         FLUSH: begin
            if ((count_q == 2'd0) && !inflight_q) begin
               state_d      = IDLE;
               done_pulse_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q         <= IDLE;
         row_count_q     <= '0;
         rd_ptr_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         inflight_last_q <= 1'b0;
         wr_idx_q        <= 1'b0;
         rd_idx_q        <= 1'b0;
         count_q         <= '0;
         drain_done_q    <= 1'b0;
         overflow_q      <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         state_q      <= state_d;
         drain_done_q <= done_pulse_d;
         if (done_i && (state_q != IDLE)) overflow_q <= 1'b1;
         if (done_i && (state_q == IDLE)) begin
            row_count_q <= n_rows;
            rd_ptr_q    <= '0;
         end else if (drain_issue) begin
            rd_ptr_q <= rd_ptr_q + 15'd1;
         end
         // Only tagged drain reads land in the FIFO; accumulate-path reads are never captured
         inflight_q      <= drain_issue;
         inflight_addr_q <= rd_ptr_q[9:0];
         inflight_last_q <= is_last;
         if (push) begin
            fifo_data_q[wr_idx_q] <= accum_rd_data_i;
            fifo_addr_q[wr_idx_q] <= inflight_addr_q;
            fifo_last_q[wr_idx_q] <= inflight_last_q;
            wr_idx_q              <= ~wr_idx_q;
         end
         if (pop) rd_idx_q <= ~rd_idx_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: doc/accum_drain_scheduler.md
ACCUM_DRAIN_SCHEDULER -- requirements
Module: accum_drain_scheduler

Interface
REQ-001 Parameter MUL_SIZE, default 32: systolic array width; rows per accumulator tile.
REQ-002 Parameter ACC_W, default 32: bits per accumulator lane.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 done_i  input  1  one-cycle pulse from the accumulator control unit: results complete.
REQ-006 V_dim_i  input  8  V dimension; sampled on done_i.
REQ-007 U_dim_i  input  8  U dimension; sampled on done_i.
REQ-008 mac_read_req_i  input  1  accumulate-path read request; highest priority.
REQ-009 mac_addr_rd_i  input  10  accumulate-path read address.
REQ-010 accum_rd_en_o  output  1  accumulator read-port enable.
REQ-011 accum_rd_addr_o  output  10  accumulator read-port address.
REQ-012 accum_rd_data_i  input  MUL_SIZE*ACC_W  read data, valid exactly 1 cycle after accum_rd_en_o.
REQ-013 out_valid_o  output  1  drained row available.
REQ-014 out_ready_i  input  1  downstream (unified buffer) accepts the row.
REQ-015 out_data_o  output  MUL_SIZE*ACC_W  drained row data.
REQ-016 out_addr_o  output  10  accumulator row index of out_data_o.
REQ-017 out_last_o  output  1  high with the final row of a drain.
REQ-018 busy_o  output  1  drain in progress.
REQ-019 drain_done_o  output  1  one-cycle pulse: all rows accepted downstream.
REQ-020 overflow_err_o  output  1  sticky: done_i arrived while busy_o was high.

Function
REQ-021 Row count N = 15-bit (V_dim_i*U_dim_i) >> 5, captured in the IDLE state on done_i.
REQ-022 States: IDLE, DRAIN, FLUSH.
- IDLE + done_i with N>0 -> DRAIN.
- IDLE + done_i with N=0 -> pulse drain_done_o the next cycle; remain in IDLE.
REQ-023 Read-port arbitration:
- mac_read_req_i=1 -> accum_rd_en_o=1 and accum_rd_addr_o=mac_addr_rd_i in the same cycle (combinational); no drain read issues that cycle.
- Otherwise the drain path may issue.
REQ-024 Drain read issues in DRAIN only when all hold:
- mac_read_req_i=0;
- skid-buffer occupancy plus in-flight reads < 2.
REQ-025 Drain reads use addresses 0..N-1 in strictly ascending order, without gaps or repeats.
REQ-026 A registered in-flight flag tags each drain read; accum_rd_data_i is written into the 2-entry FIFO only on the cycle after a tagged read; data from mac reads is never captured.
REQ-027 FIFO ordering and output:
- FIFO stores {data, addr, last}; out_valid_o = FIFO non-empty.
- Head is presented on out_data_o/out_addr_o/out_last_o and pops on out_valid_o & out_ready_i.
REQ-028 Once out_valid_o is high, out_valid_o and the presented row stay stable until accepted.
REQ-029 Simultaneous FIFO push and pop is legal at any occupancy 1..2; occupancy stays unchanged.
REQ-030 Issuing read address N-1 -> FLUSH.
REQ-031 FLUSH -> IDLE when the FIFO is empty and no read is in flight; drain_done_o pulses on that transition.
REQ-032 busy_o = 1 in DRAIN and FLUSH; busy_o = 0 in IDLE.
REQ-033 done_i while not in IDLE:
- it is ignored;
- overflow_err_o is set and stays set until reset.
REQ-034 Best-case throughput is one row per cycle, with out_ready_i=1 and no mac requests; done_i-to-first out_valid_o latency is 3 cycles.

Reset
REQ-035 rst_i low asynchronously forces:
- state IDLE;
- FIFO empty and in-flight flag clear;
- all counters 0;
- out_valid_o, out_last_o, busy_o, drain_done_o, overflow_err_o, accum_rd_en_o (drain term) = 0;
- out_data_o, out_addr_o = 0.
REQ-036 Reset asserted mid-drain abandons the drain; no drain_done_o pulse follows reset release.

Verification
REQ-037 V=32, U=32 (N=32), out_ready_i=1, no mac requests -> rows 0..31 on 32 consecutive cycles starting 3 cycles after done_i; out_last_o with row 31; drain_done_o pulses once.
REQ-038 V=64, U=64 (N=128), out_ready_i toggled 1/0 each cycle -> all 128 rows in order, no loss or duplication, outputs stable while stalled.
REQ-039 mac_read_req_i held high 10 cycles mid-drain -> drain addresses pause, accum_rd_addr_o equals mac_addr_rd_i, mac data never appears on out_data_o.
REQ-040 done_i with V=0 -> busy_o stays 0, drain_done_o pulses next cycle.
REQ-041 Second done_i during a drain -> overflow_err_o=1 sticky, first drain still completes with N rows.
REQ-042 rst_i low at row 10 of N=32 -> all outputs 0 immediately; after release, idle until next done_i, no drain_done_o.
